// File: rtl/control_unit.sv
// control_unit
// Fetch/decode/sequencing FSM for the 8-bit processor. Owns PC, IR, the
// accumulator and the latched flag register, and issues operations to the ALU.
//
// Ports:
//   clk, rst_n             system clock (rising edge), async active-low reset
//   pm_addr, pm_rd         program ROM address and read strobe
//   pm_data                ROM data, valid the cycle after pm_rd
//   rf_addr, rf_rdata      register-file index and combinational read data
//   rf_we, rf_wdata        register-file write strobe and data (always acu)
//   acu                    accumulator (ALU acu operand)
//   alu_instruction_code   ALU operation select, IDLE_CODE outside EXEC
//   alu_data, alu_flag_*   registered ALU result and flags
//   flags                  latched {s,p,cy,z}
//   halted                 high while in HALT
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FETCH      | present PC to the ROM with pm_rd
// DECODE     | latch IR, advance PC, latch rf_addr, dispatch on opcode
// EXEC       | drive the ALU code for exactly one cycle
// WAIT       | ALU computing; code back to idle
// WB         | acu <= alu_data, flags latched
// LOAD       | acu <= R[n]
// STORE      | one-cycle register-file write of acu
// ARG_FETCH  | read the jump target byte at PC
// ARG_LOAD   | PC <= target if taken, otherwise step over the target byte
// HALT       | all strobes idle until reset

module control_unit #(
    parameter int         PC_W      = 8,
    parameter logic [3:0] IDLE_CODE = 4'hF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] pm_addr,
    output logic            pm_rd,
    input  logic [7:0]      pm_data,
    output logic [3:0]      rf_addr,
    input  logic [7:0]      rf_rdata,
    output logic            rf_we,
    output logic [7:0]      rf_wdata,
    output logic [7:0]      acu,
    output logic [3:0]      alu_instruction_code,
    input  logic [7:0]      alu_data,
    input  logic            alu_flag_z,
    input  logic            alu_flag_cy,
    input  logic            alu_flag_p,
    input  logic            alu_flag_s,
    output logic [3:0]      flags,
    output logic            halted
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_WB,
        S_LOAD,
        S_STORE,
        S_ARG_FETCH,
        S_ARG_LOAD,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_LD  = 4'hA;
    localparam logic [3:0] OP_ST  = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JC  = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic            jump_taken;

    // flags is {s,p,cy,z}
    assign jump_taken = (ir[7:4] == OP_JMP)
                     || ((ir[7:4] == OP_JZ) && flags[0])
                     || ((ir[7:4] == OP_JC) && flags[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            ir      <= '0;
            acu     <= '0;
            flags   <= '0;
            rf_addr <= '0;
        end else begin
            case (state)
                S_DECODE: begin
                    ir      <= pm_data;
                    pc      <= pc + PC_W'(1);
                    rf_addr <= pm_data[3:0];
                end
                S_WB: begin
                    acu   <= alu_data;
                    flags <= {alu_flag_s, alu_flag_p, alu_flag_cy, alu_flag_z};
                end
                S_LOAD: begin
                    acu <= rf_rdata;
                end
                S_ARG_LOAD: begin
                    if (jump_taken) begin
                        pc <= PC_W'(pm_data);
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt            = state;
        pm_rd                = 1'b0;
        rf_we                = 1'b0;
        alu_instruction_code = IDLE_CODE;
        halted               = 1'b0;
        case (state)
            S_FETCH: begin
                // Gated by rst_n so the read strobe is quiet while reset is held.
                pm_rd     = rst_n;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (pm_data[7:4] <= 4'h9) begin
                    state_nxt = S_EXEC;
                end else if (pm_data[7:4] == OP_LD) begin
                    state_nxt = S_LOAD;
                end else if (pm_data[7:4] == OP_ST) begin
                    state_nxt = S_STORE;
                end else if (pm_data[7:4] != 4'hF) begin
                    state_nxt = S_ARG_FETCH;
                end else if (pm_data[3:0] == 4'h0) begin
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_HALT;
                end
            end
            S_EXEC: begin
                alu_instruction_code = ir[7:4];
                state_nxt            = S_WAIT;
            end
            S_WAIT: begin
                state_nxt = S_WB;
            end
            S_WB: begin
                state_nxt = S_FETCH;
            end
            S_LOAD: begin
                state_nxt = S_FETCH;
            end
            S_STORE: begin
                rf_we     = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ARG_FETCH: begin
                pm_rd     = 1'b1;
                state_nxt = S_ARG_LOAD;
            end
            S_ARG_LOAD: begin
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign pm_addr  = pc;
    assign rf_wdata = acu;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pm_addr;
    logic       pm_rd;
    logic [7:0] pm_data;
    logic [3:0] rf_addr;
    logic [7:0] rf_rdata;
    logic       rf_we;
    logic [7:0] rf_wdata;
    logic [7:0] acu;
    logic [3:0] alu_instruction_code;
    logic [7:0] alu_data;
    logic       alu_flag_z, alu_flag_cy, alu_flag_p, alu_flag_s;
    logic [3:0] flags;
    logic       halted;

    int tests = 0;
    int fails = 0;

    logic [7:0] rom [256];
    logic [7:0] rf  [16];

    always #5 clk = ~clk;

    control_unit #(.PC_W(8), .IDLE_CODE(4'hF)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .pm_addr              (pm_addr),
        .pm_rd                (pm_rd),
        .pm_data              (pm_data),
        .rf_addr              (rf_addr),
        .rf_rdata             (rf_rdata),
        .rf_we                (rf_we),
        .rf_wdata             (rf_wdata),
        .acu                  (acu),
        .alu_instruction_code (alu_instruction_code),
        .alu_data             (alu_data),
        .alu_flag_z           (alu_flag_z),
        .alu_flag_cy          (alu_flag_cy),
        .alu_flag_p           (alu_flag_p),
        .alu_flag_s           (alu_flag_s),
        .flags                (flags),
        .halted               (halted)
    );

    // Synchronous program ROM
    always @(posedge clk) begin
        if (pm_rd) pm_data <= rom[pm_addr];
    end

    // Register file: combinational read, clocked write
    assign rf_rdata = rf[rf_addr];
    always @(posedge clk) begin
        if (rf_we) rf[rf_addr] = rf_wdata;
    end

    // ALU model: data and cy registered on the op edge, z/p/s one edge later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_data    <= 8'h00;
            alu_flag_cy <= 1'b0;
            alu_flag_z  <= 1'b0;
            alu_flag_p  <= 1'b0;
            alu_flag_s  <= 1'b0;
        end else begin
            case (alu_instruction_code)
                4'h0: alu_data <= ~acu;
                4'h1: alu_data <= acu ^ rf_rdata;
                4'h2: alu_data <= acu | rf_rdata;
                4'h3: alu_data <= acu & rf_rdata;
                4'h4: alu_data <= acu - rf_rdata;
                4'h5: {alu_flag_cy, alu_data} <= {1'b0, acu} + {1'b0, rf_rdata};
                4'h6: alu_data <= {acu[0], acu[7:1]};
                4'h7: alu_data <= {acu[6:0], acu[7]};
                4'h8: alu_data <= acu - 8'h01;
                4'h9: alu_data <= acu + 8'h01;
                default: ;
            endcase
            alu_flag_z <= (alu_data == 8'h00);
            alu_flag_p <= ~^alu_data;
            alu_flag_s <= alu_data[7];
        end
    end

    // pm_rd and rf_we must never overlap
    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (pm_rd && rf_we) begin
                fails++;
                $display("FAIL strobe_overlap pm_rd=%b rf_we=%b want not both", pm_rd, rf_we);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench just after a negedge with reset released: the FETCH of address 0.
    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_mem();
        rst_n = 1'b0;
        step(2);
        tests++;
        if ({pm_rd, rf_we, halted} !== 3'b000) begin
            fails++;
            $display("FAIL reset_strobes got %b want 000", {pm_rd, rf_we, halted});
        end
        tests++;
        if ({acu, flags} !== 12'h000) begin
            fails++;
            $display("FAIL reset_acu_flags got %h want 000", {acu, flags});
        end
        tests++;
        if (alu_instruction_code !== 4'hF || pm_addr !== 8'h00) begin
            fails++;
            $display("FAIL reset_code_pc got code=%h pc=%h want F/00", alu_instruction_code, pm_addr);
        end
    endtask

    task automatic test_nop();
        clear_mem();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (pm_rd !== 1'b1 || pm_addr !== 8'(i)) begin
                fails++;
                $display("FAIL nop_fetch got rd=%b addr=%h want 1/%h", pm_rd, pm_addr, 8'(i));
            end
            step(1);
            tests++;
            if (pm_rd !== 1'b0) begin
                fails++;
                $display("FAIL nop_decode_rd got %b want 0", pm_rd);
            end
            step(1);
        end
        tests++;
        if ({acu, flags, halted} !== 13'h0) begin
            fails++;
            $display("FAIL nop_state got %h want 0", {acu, flags, halted});
        end
    endtask

    task automatic test_alu_store();
        clear_mem();
        rom[0] = 8'hA1; rom[1] = 8'h52; rom[2] = 8'hB3; rom[3] = 8'hF1;
        rf[1] = 8'hF0; rf[2] = 8'h20; rf[3] = 8'h00;
        do_reset();
        step(3);
        tests++;
        if (acu !== 8'hF0) begin
            fails++;
            $display("FAIL ld_acu got %h want F0", acu);
        end
        step(1);
        tests++;
        if (alu_instruction_code !== 4'hF) begin
            fails++;
            $display("FAIL code_decode got %h want F", alu_instruction_code);
        end
        step(1);
        tests++;
        if (alu_instruction_code !== 4'h5) begin
            fails++;
            $display("FAIL code_exec got %h want 5", alu_instruction_code);
        end
        step(1);
        tests++;
        if (alu_instruction_code !== 4'hF) begin
            fails++;
            $display("FAIL code_wait got %h want F", alu_instruction_code);
        end
        step(2);
        tests++;
        if (acu !== 8'h10 || flags !== 4'h2) begin
            fails++;
            $display("FAIL add_result got acu=%h flags=%h want 10/2", acu, flags);
        end
        step(1);
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL st_decode_we got %b want 0", rf_we);
        end
        step(1);
        tests++;
        if (rf_we !== 1'b1 || rf_wdata !== 8'h10 || rf_addr !== 4'h3) begin
            fails++;
            $display("FAIL st_write got we=%b d=%h a=%h want 1/10/3", rf_we, rf_wdata, rf_addr);
        end
        step(1);
        tests++;
        if (rf_we !== 1'b0 || rf[3] !== 8'h10) begin
            fails++;
            $display("FAIL st_done got we=%b r3=%h want 0/10", rf_we, rf[3]);
        end
    endtask

    task automatic test_jz(input logic [7:0] r0, input logic [3:0] exp_flags,
                           input logic [7:0] exp_addr);
        clear_mem();
        rom[0] = 8'hF0; rom[1] = 8'hA0; rom[2] = 8'h80; rom[3] = 8'hC0; rom[4] = 8'h40;
        rom[5] = 8'hF1; rom[8'h40] = 8'hF1;
        rf[0] = r0;
        do_reset();
        step(10);
        tests++;
        if (flags !== exp_flags) begin
            fails++;
            $display("FAIL jz_flags r0=%h got %h want %h", r0, flags, exp_flags);
        end
        step(2);
        tests++;
        if (pm_rd !== 1'b1 || pm_addr !== 8'h04) begin
            fails++;
            $display("FAIL jz_arg got rd=%b addr=%h want 1/04", pm_rd, pm_addr);
        end
        step(2);
        tests++;
        if (pm_rd !== 1'b1 || pm_addr !== exp_addr) begin
            fails++;
            $display("FAIL jz_target r0=%h got rd=%b addr=%h want 1/%h", r0, pm_rd, pm_addr, exp_addr);
        end
    endtask

    task automatic test_jump_wrap();
        clear_mem();
        rom[0] = 8'hE0; rom[1] = 8'hFE; rom[8'hFE] = 8'hE0; rom[8'hFF] = 8'h00;
        do_reset();
        step(4);
        tests++;
        if (pm_rd !== 1'b1 || pm_addr !== 8'hFE) begin
            fails++;
            $display("FAIL jmp_fe got rd=%b addr=%h want 1/FE", pm_rd, pm_addr);
        end
        step(2);
        tests++;
        if (pm_rd !== 1'b1 || pm_addr !== 8'hFF) begin
            fails++;
            $display("FAIL jmp_arg_ff got rd=%b addr=%h want 1/FF", pm_rd, pm_addr);
        end
        step(2);
        tests++;
        if (pm_rd !== 1'b1 || pm_addr !== 8'h00) begin
            fails++;
            $display("FAIL jmp_to_00 got rd=%b addr=%h want 1/00", pm_rd, pm_addr);
        end

        clear_mem();
        rom[0] = 8'hE0; rom[1] = 8'hFF; rom[8'hFF] = 8'hF0;
        do_reset();
        step(6);
        tests++;
        if (pm_rd !== 1'b1 || pm_addr !== 8'h00) begin
            fails++;
            $display("FAIL pc_wrap got rd=%b addr=%h want 1/00", pm_rd, pm_addr);
        end

        clear_mem();
        rom[0] = 8'hE0; rom[1] = 8'h10; rom[8'h10] = 8'hE0; rom[8'h11] = 8'h10;
        do_reset();
        step(8);
        tests++;
        if (pm_rd !== 1'b1 || pm_addr !== 8'h10) begin
            fails++;
            $display("FAIL tight_loop got rd=%b addr=%h want 1/10", pm_rd, pm_addr);
        end
    endtask

    task automatic test_reset_mid_exec();
        clear_mem();
        rom[0] = 8'hA1; rom[1] = 8'h52; rom[2] = 8'hB3;
        rf[1] = 8'hF0; rf[2] = 8'h20; rf[3] = 8'h55;
        do_reset();
        step(5);
        tests++;
        if (alu_instruction_code !== 4'h5) begin
            fails++;
            $display("FAIL mid_exec_code got %h want 5", alu_instruction_code);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (alu_instruction_code !== 4'hF || acu !== 8'h00 || rf_we !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_now got code=%h acu=%h we=%b want F/00/0",
                     alu_instruction_code, acu, rf_we);
        end
        for (int i = 0; i < 3; i++) begin
            step(1);
            tests++;
            if (acu !== 8'h00 || rf_we !== 1'b0 || pm_rd !== 1'b0) begin
                fails++;
                $display("FAIL mid_reset_hold got acu=%h we=%b rd=%b want 00/0/0", acu, rf_we, pm_rd);
            end
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (pm_rd !== 1'b1 || pm_addr !== 8'h00 || rf[3] !== 8'h55) begin
            fails++;
            $display("FAIL mid_reset_release got rd=%b addr=%h r3=%h want 1/00/55", pm_rd, pm_addr, rf[3]);
        end
    endtask

    task automatic test_halt();
        clear_mem();
        rom[0] = 8'hF1;
        do_reset();
        step(1);
        tests++;
        if (halted !== 1'b0) begin
            fails++;
            $display("FAIL halt_decode got %b want 0", halted);
        end
        step(1);
        for (int i = 0; i < 20; i++) begin
            tests++;
            if (halted !== 1'b1 || pm_rd !== 1'b0 || rf_we !== 1'b0) begin
                fails++;
                $display("FAIL halt_hold cyc=%0d got h=%b rd=%b we=%b want 1/0/0", i, halted, pm_rd, rf_we);
            end
            step(1);
        end
    endtask

    initial begin
        pm_data = 8'h00;
        test_reset();
        test_nop();
        test_alu_store();
        test_jz(8'h01, 4'h5, 8'h40);
        test_jz(8'h02, 4'h0, 8'h05);
        test_jump_wrap();
        test_reset_mid_exec();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
